// File: rtl/wb_accel_regs_if.sv
// wb_accel_regs_if: Wishbone classic slave-port signal bundle for the accelerator register block
interface wb_accel_regs_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master(output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, input wbs_ack_o, wbs_dat_o);
  modport slave(input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wb_accel_regs.sv
// wb_accel_regs: Wishbone register front-end that loads, starts, times and reads back one accelerator
module wb_accel_regs #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wb_accel_regs_if.slave    bus,
  output logic [31:0]       op_a_o,
  output logic [31:0]       op_b_o,
  output logic [31:0]       op_c_o,
  output logic [3:0]        mode_o,
  output logic              start_o,
  input  logic              done_i,
  input  logic [31:0]       result_i,
  output logic              irq_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic acc, wr, op_wr, ctrl_wr, w1c, go, fin_done, fin_tout, busy, irq_en, done, tout;
  logic [2:0] idx;
  logic [15:0] cnt, cnt_inc, cycles;
  logic [31:0] result, rdat;
  logic [31:0] regs [8];
  logic unused_adr;
  assign acc = bus.wbs_stb_i & bus.wbs_cyc_i & (bus.wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~bus.wbs_ack_o;
  assign wr = acc & bus.wbs_we_i;
  assign idx = bus.wbs_adr_i[4:2];
  assign busy = state == BUSY;
  assign op_wr = wr & ~busy;
  assign ctrl_wr = wr & (idx == 3'd3) & bus.wbs_sel_i[0];
  assign w1c = wr & (idx == 3'd4) & bus.wbs_sel_i[0];
  assign cnt_inc = cnt + 16'd1;
  assign irq_o = irq_en & (done | tout);
  assign rdat = regs[idx];
  assign unused_adr = &{1'b0, bus.wbs_adr_i[7:5], bus.wbs_adr_i[1:0]};
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  // read view of the register map
  always_comb begin
    regs[0] = op_a_o;
    regs[1] = op_b_o;
    regs[2] = op_c_o;
    regs[3] = {24'd0, mode_o, 2'b00, irq_en, 1'b0};
    regs[4] = {29'd0, tout, done, busy};
    regs[5] = result;
    regs[6] = {16'd0, cycles};
    regs[7] = 32'd0;
  end
  // next state: start from idle, finish on done (priority) or timeout
  always_comb begin
    state_n = state;
    go = 1'b0;
    fin_done = 1'b0;
    fin_tout = 1'b0;
    if (!busy) begin
      go = ctrl_wr & bus.wbs_dat_i[0];
      state_n = go ? BUSY : IDLE;
    end else begin
      fin_done = done_i;
      fin_tout = ~done_i & (cnt_inc == TIMEOUT);
      state_n = (fin_done | fin_tout) ? IDLE : BUSY;
    end
  end
  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else state <= state_n;
  end
  // bus response: one-cycle ack with registered read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= 32'd0;
    end else begin
      bus.wbs_ack_o <= acc;
      bus.wbs_dat_o <= (acc & ~bus.wbs_we_i) ? rdat : 32'd0;
    end
  end
  // operand and control registers, frozen while the accelerator runs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      op_a_o <= 32'd0;
      op_b_o <= 32'd0;
      op_c_o <= 32'd0;
      mode_o <= 4'd0;
      irq_en <= 1'b0;
    end else begin
      if (op_wr & (idx == 3'd0)) op_a_o <= merge(op_a_o, bus.wbs_dat_i, bus.wbs_sel_i);
      if (op_wr & (idx == 3'd1)) op_b_o <= merge(op_b_o, bus.wbs_dat_i, bus.wbs_sel_i);
      if (op_wr & (idx == 3'd2)) op_c_o <= merge(op_c_o, bus.wbs_dat_i, bus.wbs_sel_i);
      if (op_wr & ctrl_wr) mode_o <= bus.wbs_dat_i[7:4];
      if (ctrl_wr) irq_en <= bus.wbs_dat_i[1];
    end
  end
  // run bookkeeping: start pulse, cycle counter, result capture, sticky status
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      start_o <= 1'b0;
      cnt <= 16'd0;
      cycles <= 16'd0;
      result <= 32'd0;
      done <= 1'b0;
      tout <= 1'b0;
    end else begin
      start_o <= go;
      cnt <= go ? 16'd0 : busy ? cnt_inc : cnt;
      cycles <= fin_done ? cnt_inc : fin_tout ? TIMEOUT : cycles;
      if (fin_done) result <= result_i;
      done <= fin_done | (done & ~(go | (w1c & bus.wbs_dat_i[1])));
      tout <= fin_tout | (tout & ~(go | (w1c & bus.wbs_dat_i[2])));
    end
  end
endmodule
